// File: rtl/surface_shader_pkg.sv
// Shared fixed-point types, colour constants and arithmetic helpers for the
// surface shading stage.
package surface_shader_pkg;

  typedef logic signed [31:0] fp;      // Q8.24
  typedef logic        [23:0] rgb_t;   // {R,G,B}

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp    FP_ONE      = 32'sh0100_0000;
  localparam rgb_t OBJ0_COLOUR = 24'hFF8040;
  localparam rgb_t OBJ1_COLOUR = 24'h40C0FF;
  localparam rgb_t BG_COLOUR   = 24'h202020;

  // Each 64-bit product is rescaled to Q8.24 before the sum, so per-term
  // truncation matches the upstream stage bit for bit.
  function automatic logic signed [33:0] vec3_dot(input vec3 a, input vec3 b);
    logic signed [63:0] px, py, pz;
    logic signed [33:0] sx, sy, sz;
    px = {{32{a.x[31]}}, a.x} * {{32{b.x[31]}}, b.x};
    py = {{32{a.y[31]}}, a.y} * {{32{b.y[31]}}, b.y};
    pz = {{32{a.z[31]}}, a.z} * {{32{b.z[31]}}, b.z};
    sx = 34'(px >>> 24);
    sy = 34'(py >>> 24);
    sz = 34'(pz >>> 24);
    return sx + sy + sz;
  endfunction

  // Scale one colour channel by an intensity in [0, 1.0]; never exceeds c.
  function automatic logic [7:0] shade_channel(input logic [7:0] c, input logic [31:0] i);
    return 8'((40'(c) * 40'(i)) >> 24);
  endfunction

endpackage

// File: rtl/shade_fifo.sv
// Synchronous FIFO for shaded pixels; simultaneous read and write are both
// honoured when full.
module shade_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count do, and
  // consumers never look at the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/surface_shader.sv
// Lambertian-plus-ambient shader: three register stages, output FIFO and a
// raster-ordered RGB888 pixel stream with frame/line markers.
module surface_shader
  import surface_shader_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480,
  parameter logic [31:0] AMBIENT = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        hit_in,
  input  logic        obj_sel,
  input  vec3         surfaceNormal,
  input  vec3         surfaceLightVector,
  output logic        almost_full,
  output logic        overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_pixel,
  output logic        out_sof,
  output logic        out_last
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam int          XW      = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int          YW      = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [31:0] ONE_U   = FP_ONE;
  localparam logic [31:0] DIFFUSE = ONE_U - AMBIENT;

  logic               s1_valid, s1_hit, s1_sel;
  logic signed [33:0] s1_dot;
  logic               s2_valid, s2_hit, s2_sel;
  logic [31:0]        s2_int;
  logic               s3_valid;
  rgb_t               s3_pixel;

  logic [31:0] d_clamp, intensity;
  logic [32:0] lit_sum;
  rgb_t        base, shaded;

  always_comb begin
    d_clamp = s1_dot[31:0];
    if (s1_dot < 34'sd0)                      d_clamp = '0;
    else if (s1_dot > $signed({2'b00, ONE_U})) d_clamp = ONE_U;
    lit_sum   = {1'b0, AMBIENT} + 33'(({32'd0, DIFFUSE} * {32'd0, d_clamp}) >> 24);
    intensity = (lit_sum > {1'b0, ONE_U}) ? ONE_U : lit_sum[31:0];
  end

  assign base   = s2_sel ? OBJ1_COLOUR : OBJ0_COLOUR;
  assign shaded = {shade_channel(base[23:16], s2_int),
                   shade_channel(base[15:8],  s2_int),
                   shade_channel(base[7:0],   s2_int)};

  // NOTE: all sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;  s1_hit <= 1'b0;  s1_sel <= 1'b0;  s1_dot <= '0;
      s2_valid <= 1'b0;  s2_hit <= 1'b0;  s2_sel <= 1'b0;  s2_int <= '0;
      s3_valid <= 1'b0;  s3_pixel <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_hit   <= hit_in;
      s1_sel   <= obj_sel;
      s1_dot   <= vec3_dot(surfaceNormal, surfaceLightVector);
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;
      s2_sel   <= s1_sel;
      s2_int   <= intensity;
      s3_valid <= s2_valid;
      s3_pixel <= s2_hit ? shaded : BG_COLOUR;
    end
  end

  logic          rd_en, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  rgb_t          fifo_head;
  logic [CW:0]   occupancy;

  shade_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s3_valid),
    .wr_data (s3_pixel),
    .rd_en   (rd_en),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Credit counts every result already committed, including those in flight.
  assign occupancy   = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid)
                     + (CW+1)'(s3_valid);
  assign almost_full = occupancy >= (CW+1)'(DEPTH - 1);

  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  assign out_valid = !fifo_empty;
  assign rd_en     = out_valid && out_ready;
  assign out_pixel = out_valid ? fifo_head : '0;
  assign out_last  = out_valid && (pix_x == X_LAST);
  assign out_sof   = out_valid && (pix_x == '0) && (pix_y == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else begin
      if (s3_valid && fifo_full && !rd_en) overflow <= 1'b1;
      if (rd_en) begin
        if (pix_x == X_LAST) begin
          pix_x <= '0;
          pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + 1'b1;
        end else begin
          pix_x <= pix_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_surface_shader.sv
// Directed bench for surface_shader: shading values, latency, credit and
// overflow, raster markers under back-pressure, and mid-operation reset.
module tb_surface_shader;
  import surface_shader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0, hit_in = 1'b0, obj_sel = 1'b0, out_ready = 1'b0;
  vec3         nrm = '0, lgt = '0;
  logic        almost_full, overflow, out_valid, out_sof, out_last;
  logic [23:0] out_pixel;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] ONE  = 32'h0100_0000;
  localparam logic [31:0] NEG1 = 32'hFF00_0000;

  surface_shader #(.DEPTH(8), .H_RES(4), .V_RES(2), .AMBIENT(32'h0020_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_in           (valid_in),
    .hit_in             (hit_in),
    .obj_sel            (obj_sel),
    .surfaceNormal      (nrm),
    .surfaceLightVector (lgt),
    .almost_full        (almost_full),
    .overflow           (overflow),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_pixel          (out_pixel),
    .out_sof            (out_sof),
    .out_last           (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec3 mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    vec3 v;
    v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one beat for one clock; called and returns at a falling edge.
  task automatic beat(input logic h, input logic s, input vec3 a, input vec3 b);
    valid_in = 1'b1; hit_in = h; obj_sel = s; nrm = a; lgt = b;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check(tag, out_valid, 1'b1);
  endtask

  task automatic wait_pixel(input string tag, input logic [23:0] exp);
    wait_valid({tag, "_valid"});
    check(tag, out_pixel, exp);
    @(negedge clk);
  endtask

  // Stimulus patterns shared by the buffering tests.
  logic        pat_hit [5];
  logic        pat_sel [5];
  vec3         pat_n   [5];
  vec3         pat_l   [5];
  logic [23:0] pat_exp [5];

  initial begin
    pat_hit[0] = 1; pat_sel[0] = 0; pat_n[0] = mk(ONE,0,0); pat_l[0] = mk(ONE,0,0);  pat_exp[0] = 24'hFF8040;
    pat_hit[1] = 1; pat_sel[1] = 1; pat_n[1] = mk(ONE,0,0); pat_l[1] = mk(ONE,0,0);  pat_exp[1] = 24'h40C0FF;
    pat_hit[2] = 0; pat_sel[2] = 0; pat_n[2] = mk(ONE,0,0); pat_l[2] = mk(NEG1,0,0); pat_exp[2] = 24'h202020;
    pat_hit[3] = 1; pat_sel[3] = 0; pat_n[3] = mk(ONE,0,0); pat_l[3] = mk(NEG1,0,0); pat_exp[3] = 24'h1F1008;
    pat_hit[4] = 1; pat_sel[4] = 1; pat_n[4] = mk(ONE,0,0); pat_l[4] = mk(0,ONE,0);  pat_exp[4] = 24'h08181F;

    // Reset state
    #12;
    check("rst_out_valid",   out_valid,   1'b0);
    check("rst_out_pixel",   out_pixel,   24'h0);
    check("rst_out_sof",     out_sof,     1'b0);
    check("rst_out_last",    out_last,    1'b0);
    check("rst_almost_full", almost_full, 1'b0);
    check("rst_overflow",    overflow,    1'b0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Full intensity, with four-cycle latency
    beat(1'b1, 1'b0, mk(ONE,0,0), mk(ONE,0,0));
    repeat (2) @(negedge clk);
    check("lat_not_yet", out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", out_valid, 1'b1);
    check("full_i_pixel", out_pixel, 24'hFF8040);
    check("first_sof", out_sof, 1'b1);
    @(negedge clk);
    check("popped", out_valid, 1'b0);

    // Back-facing light clamps d to 0, ambient only
    beat(1'b1, 1'b0, mk(ONE,0,0), mk(NEG1,0,0));
    wait_pixel("ambient_obj0", 24'h1F1008);
    // d one LSB below 0.5
    beat(1'b1, 1'b1, mk(ONE,0,0), mk(32'h007F_FFFF,0,0));
    wait_pixel("half_minus_obj1", 24'h236B8F);
    // d exactly 0.5 via a negative product term
    beat(1'b1, 1'b1, mk(ONE,ONE,0), mk(ONE,32'hFF80_0000,0));
    wait_pixel("half_exact_obj1", 24'h246C8F);
    // d = 2.0 clamps to 1.0
    beat(1'b1, 1'b1, mk(32'h0200_0000,0,0), mk(ONE,0,0));
    wait_pixel("clamp_high_obj1", 24'h40C0FF);
    // Miss ignores the vectors
    beat(1'b0, 1'b1, mk(32'h1234_5678,32'h8000_0001,ONE), mk(ONE,NEG1,32'h0555_0000));
    wait_pixel("miss_bg", 24'h202020);

    // Credit and overflow with the sink stalled
    rst = 1'b0; #1 rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      beat(pat_hit[i%5], pat_sel[i%5], pat_n[i%5], pat_l[i%5]);
      if (i == 5)  check("af_at_6", almost_full, 1'b0);
      if (i == 6)  check("af_at_7", almost_full, 1'b1);
      if (i == 10) check("ovf_before_drop", overflow, 1'b0);
    end
    check("ovf_set", overflow, 1'b1);
    repeat (4) @(negedge clk);
    check("ovf_sticky", overflow, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_valid_%0d", k), out_valid, 1'b1);
      check($sformatf("drain_pixel_%0d", k), out_pixel, pat_exp[k%5]);
      @(negedge clk);
    end
    check("drain_empty", out_valid, 1'b0);

    // Raster markers with a toggling sink, producer honouring almost_full
    rst = 1'b0; #1 rst = 1'b1;
    out_ready = 1'b0;
    fork
      begin
        int sent = 0;
        for (int c = 0; c < 300 && sent < 9; c++) begin
          if (!almost_full) begin
            beat(1'b1, sent[0], mk(ONE,0,0), mk(ONE,0,0));
            sent++;
          end else begin
            @(negedge clk);
          end
        end
      end
      begin
        int          got = 0;
        logic        stalled = 1'b0;
        logic [23:0] sv_pix = '0;
        logic        sv_sof = 1'b0, sv_last = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 9; cyc++) begin
          if (stalled) begin
            check("stall_pixel", out_pixel, sv_pix);
            check("stall_sof",   out_sof,   sv_sof);
            check("stall_last",  out_last,  sv_last);
          end
          out_ready = cyc[0];
          if (out_valid && out_ready) begin
            got++;
            check($sformatf("raster_pix_%0d", got), out_pixel, got[0] ? 24'hFF8040 : 24'h40C0FF);
            check($sformatf("raster_sof_%0d", got), out_sof, (got == 1 || got == 9));
            check($sformatf("raster_last_%0d", got), out_last, (got == 4 || got == 8));
            stalled = 1'b0;
          end else if (out_valid) begin
            stalled = 1'b1;
            sv_pix = out_pixel; sv_sof = out_sof; sv_last = out_last;
          end else begin
            stalled = 1'b0;
          end
          @(negedge clk);
        end
        check("raster_count", got, 9);
      end
    join
    check("raster_no_ovf", overflow, 1'b0);

    // Reset with 3 beats in flight and 2 buffered
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) beat(pat_hit[1], pat_sel[1], pat_n[1], pat_l[1]);
    check("pre_rst_valid", out_valid, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid",  out_valid,   1'b0);
    check("mid_rst_pixel",  out_pixel,   24'h0);
    check("mid_rst_sof",    out_sof,     1'b0);
    check("mid_rst_last",   out_last,    1'b0);
    check("mid_rst_af",     almost_full, 1'b0);
    check("mid_rst_ovf",    overflow,    1'b0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_empty", out_valid, 1'b0);
    beat(pat_hit[2], pat_sel[2], pat_n[2], pat_l[2]);
    wait_valid("post_rst_wait");
    check("post_rst_pixel", out_pixel, 24'h202020);
    check("post_rst_sof",   out_sof,   1'b1);
    check("post_rst_ovf",   overflow,  1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
